// File: rtl/mc_burst_adr.sv
// Burst address sequencer: emits one address per beat on adv, with the next
// beat address precomputed in a registered split incrementer for full-rate bursts.
module mc_burst_adr #(
  parameter int aw    = 24,
  parameter int col_w = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [aw-1:0] adr_in,
  input  logic [2:0]    bl,
  input  logic          wrap,
  input  logic          adv,
  output logic [aw-1:0] adr_out,
  output logic          adr_vld,
  output logic          last,
  output logic          busy
);

  // state    | meaning
  // st_idle  | no valid beat on adr_out
  // st_run   | adr_out holds a valid beat, burst in progress
  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_run  = 1'b1;

  localparam int lo_w  = aw / 2;
  localparam int hi_w  = aw - lo_w;
  localparam int cnt_w = (col_w > 3) ? col_w : 3;

  logic [0:0]      state;
  logic [aw-1:0]   adr_q;
  logic [aw-1:0]   adr_nxt;
  logic            nxt_carry;
  logic [aw-1:0]   mask_q;
  logic [cnt_w-1:0] cnt;
  logic            last_q;

  logic [aw-1:0]    ld_mask;
  logic [aw-1:0]    ld_nxt;
  logic [aw-1:0]    run_nxt;
  logic [cnt_w-1:0] ld_cnt;

  function automatic int log2_beats(input logic [2:0] b);
    case (b)
      3'd1:    return 1;
      3'd2:    return 2;
      3'd3:    return 3;
      default: return 0;
    endcase
  endfunction

  // Bits of the address that increment; all other bits are held.
  function automatic logic [aw-1:0] mask_of(input logic [2:0] b, input logic w);
    logic [aw-1:0] m;
    int            k;
    m = '0;
    k = log2_beats(b);
    for (int i = 0; i < aw; i++) begin
      if (b == 3'd7)
        m[i] = (i < col_w);
      else if (!w)
        m[i] = 1'b1;
      else
        m[i] = (i < k);
    end
    return m;
  endfunction

  function automatic logic [cnt_w-1:0] beats_m1(input logic [2:0] b);
    case (b)
      3'd1:    return cnt_w'(1);
      3'd2:    return cnt_w'(3);
      3'd3:    return cnt_w'(7);
      3'd7:    return cnt_w'((64'd1 << col_w) - 64'd1);
      default: return '0;
    endcase
  endfunction

  // Two independent half-width adders; the carry into the upper half comes
  // from a flag computed ahead of time rather than from the lower adder.
  function automatic logic [aw-1:0] f_inc(input logic [aw-1:0] a,
                                          input logic [aw-1:0] m,
                                          input logic          carry);
    logic [lo_w-1:0] lo_sum;
    logic [hi_w-1:0] hi_sum;
    logic [aw-1:0]   inc;
    lo_sum = a[lo_w-1:0] + lo_w'(1);
    hi_sum = a[aw-1:lo_w] + hi_w'(carry);
    inc    = {hi_sum, lo_sum};
    return (a & ~m) | (inc & m);
  endfunction

  always_comb begin
    ld_mask = mask_of(bl, wrap);
    ld_cnt  = beats_m1(bl);
    ld_nxt  = f_inc(adr_in, ld_mask, &adr_in[lo_w-1:0]);
    run_nxt = f_inc(adr_nxt, mask_q, nxt_carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= st_idle;
      adr_q     <= '0;
      adr_nxt   <= '0;
      nxt_carry <= 1'b0;
      mask_q    <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
    end else if (ld) begin
      state     <= st_run;
      adr_q     <= adr_in;
      adr_nxt   <= ld_nxt;
      nxt_carry <= &ld_nxt[lo_w-1:0];
      mask_q    <= ld_mask;
      cnt       <= ld_cnt;
      last_q    <= (ld_cnt == '0);
    end else if (adv && state == st_run) begin
      if (last_q) begin
        state  <= st_idle;
        last_q <= 1'b0;
      end else begin
        adr_q     <= adr_nxt;
        adr_nxt   <= run_nxt;
        nxt_carry <= &run_nxt[lo_w-1:0];
        cnt       <= cnt - cnt_w'(1);
        last_q    <= (cnt == cnt_w'(1));
      end
    end
  end

  assign adr_out = adr_q;
  assign adr_vld = (state == st_run);
  assign busy    = (state == st_run);
  assign last    = last_q;

endmodule

// File: tb/tb_mc_burst_adr.sv
// Self-checking bench for mc_burst_adr: table vectors for the directed bursts,
// a behavioural reference model for the full-page and random traffic.
module tb_mc_burst_adr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld = 1'b0;
  logic [23:0] adr_in = '0;
  logic [2:0]  bl = '0;
  logic        wrap = 1'b0;
  logic        adv = 1'b0;
  logic [23:0] adr_out;
  logic        adr_vld;
  logic        last;
  logic        busy;

  mc_burst_adr #(.aw(24), .col_w(8)) dut (
    .clk(clk), .rst(rst), .ld(ld), .adr_in(adr_in), .bl(bl), .wrap(wrap),
    .adv(adv), .adr_out(adr_out), .adr_vld(adr_vld), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [23:0] a;
    logic [2:0]  bl;
    logic        w;
    logic        adv;
    logic [23:0] e_adr;
    logic        e_vld;
    logic        e_last;
  } vec_t;

  typedef struct {
    logic [23:0] adr;
    logic        vld;
    logic        last;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // reference model state
  int m_adr = 0, m_rem = 0, m_bl = 0;
  bit m_vld = 0, m_last = 0, m_w = 0;

  function automatic int beats_of(input int b);
    case (b)
      1: return 2;
      2: return 4;
      3: return 8;
      7: return 256;
      default: return 1;
    endcase
  endfunction

  function automatic int ref_next(input int a, input int b, input bit w);
    int blk;
    if (b == 7) blk = 256;
    else if (!w) return (a + 1) % (1 << 24);
    else blk = beats_of(b);
    return (a - (a % blk)) + ((a + 1) % blk);
  endfunction

  task automatic model_reset();
    m_adr = 0; m_rem = 0; m_bl = 0; m_vld = 0; m_last = 0; m_w = 0;
  endtask

  task automatic model_step(input bit l, input int a, input int b, input bit w, input bit v);
    if (l) begin
      m_adr = a; m_vld = 1; m_bl = b; m_w = w;
      m_rem = beats_of(b) - 1; m_last = (m_rem == 0);
    end else if (v && m_vld) begin
      if (m_last) begin
        m_vld = 0; m_last = 0;
      end else begin
        m_adr = ref_next(m_adr, m_bl, m_w);
        m_rem = m_rem - 1; m_last = (m_rem == 0);
      end
    end
  endtask

  task automatic chk(input string nm, input exp_t e);
    n_tot++;
    if (adr_out === e.adr && adr_vld === e.vld && last === e.last && busy === e.vld)
      n_pass++;
    else
      $display("FAIL %s: got adr=%06h vld=%0b last=%0b busy=%0b, expected adr=%06h vld=%0b last=%0b",
               nm, adr_out, adr_vld, last, busy, e.adr, e.vld, e.last);
  endtask

  // Drive one cycle of inputs, queue the expectation, sample just after the edge.
  task automatic step(input bit l, input logic [23:0] a, input logic [2:0] b, input bit w,
                      input bit v, input bit use_tbl, input exp_t te, input string nm);
    exp_t e;
    ld = l; adr_in = a; bl = b; wrap = w; adv = v;
    model_step(l, int'(a), int'(b), w, v);
    if (use_tbl) sb.push_back(te);
    else sb.push_back('{adr: 24'(m_adr), vld: m_vld, last: m_last});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(nm, e);
  endtask

  task automatic add(input bit l, input logic [23:0] a, input logic [2:0] b, input bit w,
                     input bit v, input logic [23:0] ea, input bit ev, input bit el);
    tbl.push_back('{ld: l, a: a, bl: b, w: w, adv: v, e_adr: ea, e_vld: ev, e_last: el});
  endtask

  exp_t none = '{adr: '0, vld: 1'b0, last: 1'b0};

  initial begin
    // linear burst of 4 across a carry boundary
    add(1, 24'h0000FE, 3'd2, 0, 0, 24'h0000FE, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h0000FF, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000100, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000101, 1, 1);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000101, 0, 0);
    // wrapped burst of 8
    add(1, 24'h000105, 3'd3, 1, 0, 24'h000105, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000106, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000107, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000100, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000101, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000102, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000103, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000104, 1, 1);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000104, 0, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000104, 0, 0);
    // ld colliding with adv mid burst
    add(1, 24'h000100, 3'd3, 0, 0, 24'h000100, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000101, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000102, 1, 0);
    add(1, 24'h000040, 3'd0, 0, 1, 24'h000040, 1, 1);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000040, 0, 0);
    // parameters captured at ld; later bl/wrap changes ignored
    add(1, 24'h000012, 3'd2, 1, 0, 24'h000012, 1, 0);
    add(0, 24'h0,      3'd7, 0, 1, 24'h000013, 1, 0);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000010, 1, 0);
    add(0, 24'h0,      3'd7, 0, 1, 24'h000011, 1, 1);
    add(0, 24'h0,      3'd7, 0, 1, 24'h000011, 0, 0);
    // reserved bl code means a single beat
    add(1, 24'h000077, 3'd5, 1, 0, 24'h000077, 1, 1);
    add(0, 24'h0,      3'd0, 0, 1, 24'h000077, 0, 0);

    // reset then idle with adv toggling
    #12 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset", none);
    for (int i = 0; i < 4; i++)
      step(0, 24'h0, 3'd0, 0, (i % 2 == 0), 0, none, "idle_adv");

    foreach (tbl[i])
      step(tbl[i].ld, tbl[i].a, tbl[i].bl, tbl[i].w, tbl[i].adv, 1,
           '{adr: tbl[i].e_adr, vld: tbl[i].e_vld, last: tbl[i].e_last}, "table");

    // full page with adv every other cycle
    step(1, 24'h1234FE, 3'd7, 0, 0, 0, none, "page_ld");
    for (int i = 0; i < 512; i++) begin
      step(0, 24'h0, 3'd0, 0, (i % 2 == 0), 0, none, "page");
      if (i == 508)
        chk("page_last", '{adr: 24'h1234FD, vld: 1'b1, last: 1'b1});
    end

    // reset mid-burst acts without a clock edge
    step(1, 24'h000200, 3'd3, 0, 0, 0, none, "rb_ld");
    step(0, 24'h0, 3'd0, 0, 1, 0, none, "rb_adv");
    step(0, 24'h0, 3'd0, 0, 1, 0, none, "rb_adv");
    adv = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", none);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", none);

    // all-ones start address wraps to zero
    step(1, 24'hFFFFFF, 3'd1, 0, 0, 1, '{adr: 24'hFFFFFF, vld: 1'b1, last: 1'b0}, "wrap_ld");
    step(0, 24'h0, 3'd0, 0, 1, 1, '{adr: 24'h000000, vld: 1'b1, last: 1'b1}, "wrap_adv");
    step(0, 24'h0, 3'd0, 0, 1, 1, '{adr: 24'h000000, vld: 1'b0, last: 1'b0}, "wrap_end");

    // random traffic against the reference model
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 7) == 0), 24'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, none, "random");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mc_burst_adr.md
Name: mc_burst_adr

Overview:
Burst address sequencer for the memory controller timing path. It loads a start column/row address and burst parameters from the access decoder, then emits one address per beat when the timing FSM advances it. The next address is precomputed one cycle ahead in a registered split incrementer, so back-to-back advances run at full clock rate. adr_out feeds the SDRAM/SRAM address mux downstream.

Parameters:
aw, 24, address width in bits (aw >= 8)
col_w, 8, column field width; full-page bursts wrap at this boundary (col_w <= aw)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ld  input  1  load start address and burst parameters
adr_in  input  aw  burst start address
bl  input  3  burst length code: 0=1, 1=2, 2=4, 3=8 beats, 7=full page (2^col_w beats), 4-6 = 1 beat
wrap  input  1  1=wrap within burst-aligned block, 0=linear increment
adv  input  1  consume current address and advance to next beat
adr_out  output  aw  current beat address
adr_vld  output  1  adr_out holds a valid beat
last  output  1  current beat is the final beat of the burst
busy  output  1  burst in progress (equals adr_vld)

Behaviour:
- Single clock domain, all state on posedge clk; rst asynchronous, active-high.
- Reset values: adr_out=0, adr_vld=0, last=0, busy=0, internal adr_nxt=0, beat counter=0, FSM=IDLE.
- FSM states: IDLE (no valid beat), RUN (adr_vld=1).
- IDLE -> RUN on ld. RUN -> RUN on adv with last=0, or on ld. RUN -> IDLE on adv with last=1 and ld=0.
- ld (accepted in any state, priority over adv): cycle n+1 has adr_out=adr_in, adr_vld=1, counter=beats-1, last=(beats==1). A burst in progress is abandoned without notice.
- adv in RUN with last=0: cycle n+1 has adr_out=adr_nxt, counter decremented, last=1 when the new counter is 0.
- adv in RUN with last=1: adr_vld=0 and last=0 at n+1; adr_out holds its final value.
- adv while adr_vld=0 is ignored with no state change.
- Next-address rule f(a), with k = log2(beats):
  - wrap=0 and bl!=7: f(a)=a+1 modulo 2^aw; all-ones wraps to 0.
  - wrap=1 and bl!=7: upper aw-k bits held; low k bits incremented modulo 2^k.
  - bl=7: upper aw-col_w bits held; low col_w bits incremented modulo 2^col_w, regardless of wrap.
  - k=0 (single beat): f unused.
- Pipelined incrementer:
  - adr_nxt is registered; it is loaded with f(adr_in) on ld and updated to f(adr_nxt) on each accepted adv.
  - Low half and carry are registered per the split-increment scheme, so there is no combinational path from adv or adr_in to the carry chain beyond one half-width adder.
  - Back-to-back adv every cycle must produce a correct sequence with no bubbles.
- Burst parameters (bl, wrap) are captured on ld; later changes have no effect until the next ld.
- Reset asserted mid-burst: all outputs return immediately (asynchronously) to reset values. The first ld after release starts cleanly.

Test Plan:
- Reset then idle: rst pulse, adv toggling -> adr_out=0, adr_vld=0, last=0 throughout.
- Linear burst 4: ld adr_in=0x0000FE, bl=2, wrap=0, adv every cycle -> adr_out 0x0000FE, 0x0000FF, 0x000100, 0x000101. last high on the 4th beat; adr_vld drops the cycle after the 4th adv.
- Wrapped burst 8: ld adr_in=0x000105, bl=3, wrap=1, continuous adv -> 0x105, 106, 107, 100, 101, 102, 103, 104; last on 0x104.
- Full page with adv gaps: ld adr_in=0x12_34FE, bl=7, col_w=8, adv every other cycle -> 0x1234FE, 0x1234FF, 0x123400, ...; address holds during gaps; 256 beats; last on 0x1234FD.
- ld during burst and adv/ld collision: mid burst-8, assert ld adr_in=0x000040, bl=0 together with adv -> next cycle adr_out=0x000040, last=1. Following adv gives adr_vld=0.
- Reset mid-burst and address wrap: rst during beat 3 -> outputs zeroed asynchronously. Then ld adr_in=0xFFFFFF, bl=1, wrap=0 -> 0xFFFFFF, then 0x000000, last=1.
